// File: rtl/gcd_controller.sv
// Control FSM for a subtract-and-compare GCD datapath: loads operand A then
// operand B, subtracts the smaller from the larger until the comparator
// reports equality, and bounds the run with an iteration counter.
//
// state | meaning
// ------+-------------------------------------------------------------
// LD_A  | waiting for operand A on data_input
// LD_B  | waiting for operand B; accepting it clears iter_cnt
// RUN   | one subtraction per cycle, steered by the EQ/LT/GT flags
// DONE  | result valid on datapath out_A, held until out_ready
// ERR   | timeout or illegal flags, held until out_ready
module gcd_controller #(
  parameter int MAX_ITER = 255,
  parameter int CNT_WID  = 9
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err,
  input  logic               EQ,
  input  logic               LT,
  input  logic               GT,
  output logic               load_A,
  output logic               load_B,
  output logic               s_in1,
  output logic               s_in2,
  output logic               s_in3,
  output logic               busy,
  output logic [CNT_WID-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    LD_A = 3'd0,
    LD_B = 3'd1,
    RUN  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_WID-1:0] cnt_q, cnt_d;

  logic flags_one_hot;
  logic at_max;

  logic in_ready_raw, out_valid_raw, err_raw, busy_raw;
  logic load_a_raw, load_b_raw, s_in1_raw, s_in2_raw, s_in3_raw;

  assign flags_one_hot = ({EQ, LT, GT} == 3'b100) || ({EQ, LT, GT} == 3'b010) ||
                         ({EQ, LT, GT} == 3'b001);
  assign at_max        = (cnt_q == CNT_WID'(MAX_ITER));

  // State and iteration counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= LD_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, counter update and datapath controls; in RUN the rules are
  // checked in priority order so illegal flags win over everything else.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    in_ready_raw  = 1'b0;
    out_valid_raw = 1'b0;
    err_raw       = 1'b0;
    busy_raw      = 1'b0;
    load_a_raw    = 1'b0;
    load_b_raw    = 1'b0;
    s_in1_raw     = 1'b0;
    s_in2_raw     = 1'b0;
    s_in3_raw     = 1'b0;
    case (state_q)
      LD_A: begin
        in_ready_raw = 1'b1;
        s_in3_raw    = 1'b1;
        load_a_raw   = in_valid;
        if (in_valid) state_d = LD_B;
      end
      LD_B: begin
        in_ready_raw = 1'b1;
        s_in3_raw    = 1'b1;
        load_b_raw   = in_valid;
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        busy_raw = 1'b1;
        if (!flags_one_hot) begin
          state_d = ERR;
        end else if (EQ) begin
          state_d = DONE;
        end else if (at_max) begin
          state_d = ERR;
        end else if (GT) begin
          s_in2_raw  = 1'b1;
          load_a_raw = 1'b1;
          cnt_d      = cnt_q + CNT_WID'(1);
        end else begin
          s_in1_raw  = 1'b1;
          load_b_raw = 1'b1;
          cnt_d      = cnt_q + CNT_WID'(1);
        end
      end
      DONE: begin
        out_valid_raw = 1'b1;
        if (out_ready) state_d = LD_A;
      end
      ERR: begin
        out_valid_raw = 1'b1;
        err_raw       = 1'b1;
        if (out_ready) state_d = LD_A;
      end
      default: begin
        state_d = LD_A;
      end
    endcase
  end

  // Every output is forced low while reset is asserted.
  assign in_ready  = in_ready_raw  & ~i_rst;
  assign out_valid = out_valid_raw & ~i_rst;
  assign err       = err_raw       & ~i_rst;
  assign busy      = busy_raw      & ~i_rst;
  assign load_A    = load_a_raw    & ~i_rst;
  assign load_B    = load_b_raw    & ~i_rst;
  assign s_in1     = s_in1_raw     & ~i_rst;
  assign s_in2     = s_in2_raw     & ~i_rst;
  assign s_in3     = s_in3_raw     & ~i_rst;
  assign iter_cnt  = i_rst ? '0 : cnt_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Testbench for gcd_controller: wraps the controller with a behavioural
// subtract/compare datapath and checks results against a scoreboard.
module tb_gcd_controller;

  localparam int MAX_ITER = 255;
  localparam int CNT_WID  = 9;

  logic               i_clk;
  logic               i_rst;
  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic               err;
  logic               EQ, LT, GT;
  logic               load_A, load_B;
  logic               s_in1, s_in2, s_in3;
  logic               busy;
  logic [CNT_WID-1:0] iter_cnt;

  logic [7:0] data_in;
  logic [7:0] reg_a, reg_b;
  logic [7:0] left_op, right_op, sub_out;
  logic       force_en, f_eq, f_lt, f_gt;

  typedef struct packed {
    logic [7:0] res;
    logic [8:0] cnt;
    logic       err;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  gcd_controller #(.MAX_ITER(MAX_ITER), .CNT_WID(CNT_WID)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err),
    .EQ       (EQ),
    .LT       (LT),
    .GT       (GT),
    .load_A   (load_A),
    .load_B   (load_B),
    .s_in1    (s_in1),
    .s_in2    (s_in2),
    .s_in3    (s_in3),
    .busy     (busy),
    .iter_cnt (iter_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural datapath: operand muxes, subtractor, A/B registers, comparator.
  assign left_op  = s_in1 ? reg_b : reg_a;
  assign right_op = s_in2 ? reg_b : reg_a;
  assign sub_out  = left_op - right_op;
  assign EQ = force_en ? f_eq : (reg_a == reg_b);
  assign LT = force_en ? f_lt : (reg_a <  reg_b);
  assign GT = force_en ? f_gt : (reg_a >  reg_b);

  always @(posedge i_clk) begin
    if (load_A) reg_a <= s_in3 ? data_in : sub_out;
    if (load_B) reg_b <= s_in3 ? data_in : sub_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference GCD by repeated subtraction with the iteration bound.
  function automatic exp_t gcd_model(input int a, input int b);
    exp_t e;
    int   x = a;
    int   y = b;
    int   c = 0;
    while (x != y && c < MAX_ITER) begin
      if (x > y) x = x - y;
      else       y = y - x;
      c++;
    end
    e.res = 8'(x);
    e.cnt = 9'(c);
    e.err = (x != y);
    return e;
  endfunction

  task automatic expect_pair(input int a, input int b);
    sb.push_back(gcd_model(a, b));
  endtask

  // Leaves the caller at the first RUN cycle, #1 after the falling edge.
  task automatic load_pair(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge i_clk); #1;
      t++;
    end
    check("ready_for_a", in_ready, 1);
    data_in  = a;
    in_valid = 1'b1;
    #1;
    check("load_a_in_ld_a", {load_A, load_B, s_in3}, 3'b101);
    @(negedge i_clk); #1;
    data_in = b;
    #1;
    check("load_b_in_ld_b", {in_ready, load_A, load_B, s_in3}, 4'b1011);
    @(negedge i_clk); #1;
    in_valid = 1'b0;
    data_in  = 8'h00;
    #1;
    check("run_busy_not_ready", {busy, in_ready}, 2'b10);
  endtask

  task automatic wait_result(input bit force_first, input int hold);
    int   lat = 0;
    exp_t e;
    if (force_first) begin
      force_en = 1'b1;
      f_eq     = 1'b1;
      f_gt     = 1'b1;
      f_lt     = 1'b0;
    end
    while (!out_valid && lat < 600) begin
      check("loads_exclusive", load_A & load_B, 0);
      lat++;
      @(negedge i_clk); #1;
    end
    force_en = 1'b0;
    check("result_valid", out_valid, 1);
    check("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) e = sb.pop_front();
    else                e = '0;
    check("result_err", err, e.err);
    check("result_iter_cnt", iter_cnt, e.cnt);
    check("result_latency", lat, e.cnt + 1);
    if (!e.err) check("result_out_a", reg_a, e.res);
    check("result_quiet", {in_ready, busy, load_A, load_B}, 4'b0000);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid  = ~in_valid;
      data_in   = 8'(8'hA5 + i);
      @(negedge i_clk); #1;
      check("hold_state", {out_valid, in_ready, load_A, load_B}, 4'b1000);
    end
    in_valid = 1'b0;
    if (hold > 0 && !e.err) check("hold_out_a", reg_a, e.res);
    out_ready = 1'b1;
    @(negedge i_clk); #1;
    check("back_to_ld_a", {in_ready, out_valid}, 2'b10);
    check("cnt_held_after", iter_cnt, e.cnt);
    out_ready = 1'b0;
  endtask

  initial begin
    i_rst     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = 8'h00;
    force_en  = 1'b0;
    f_eq      = 1'b0;
    f_lt      = 1'b0;
    f_gt      = 1'b0;

    // Power-on reset: every output low.
    @(negedge i_clk); #1;
    check("rst_outputs", {in_ready, out_valid, err, busy, load_A, load_B, s_in1, s_in2, s_in3}, 0);
    @(negedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_cnt", iter_cnt, 0);

    // (12,8): first RUN cycle is GT -> A <= A-B.
    expect_pair(12, 8);
    load_pair(8'd12, 8'd8);
    check("gt_controls", {s_in1, s_in2, s_in3, load_A, load_B}, 5'b01010);
    wait_result(1'b0, 0);

    // (255,1): 254 subtractions, finishes just under the bound.
    expect_pair(255, 1);
    load_pair(8'd255, 8'd1);
    wait_result(1'b0, 0);

    // (5,0): never converges, ends in ERR at the iteration bound.
    expect_pair(5, 0);
    load_pair(8'd5, 8'd0);
    wait_result(1'b0, 0);

    // (0,0): immediate EQ.
    expect_pair(0, 0);
    load_pair(8'd0, 8'd0);
    wait_result(1'b0, 0);

    // Illegal EQ&GT flags on the first RUN cycle -> ERR next edge.
    sb.push_back('{res: 8'd0, cnt: 9'd0, err: 1'b1});
    load_pair(8'd20, 8'd7);
    wait_result(1'b1, 0);

    // Backpressure in DONE for 10 cycles with in_valid pulses.
    expect_pair(21, 14);
    load_pair(8'd21, 8'd14);
    wait_result(1'b0, 10);

    // LT on the first RUN cycle.
    expect_pair(6, 15);
    load_pair(8'd6, 8'd15);
    check("lt_controls", {s_in1, s_in2, s_in3, load_A, load_B}, 5'b10001);
    wait_result(1'b0, 0);

    // Reset in the middle of (200,3).
    load_pair(8'd200, 8'd3);
    repeat (5) @(negedge i_clk);
    #1;
    check("cnt_before_rst", iter_cnt, 5);
    i_rst = 1'b1;
    #1;
    check("midrun_rst_outputs",
          {in_ready, out_valid, err, busy, load_A, load_B, s_in1, s_in2, s_in3}, 0);
    check("midrun_rst_cnt", iter_cnt, 0);
    @(negedge i_clk); #1;
    i_rst = 1'b0;
    #1;
    check("after_midrun_rst", {in_ready, busy, out_valid}, 3'b100);
    check("after_midrun_cnt", iter_cnt, 0);
    expect_pair(9, 6);
    load_pair(8'd9, 8'd6);
    wait_result(1'b0, 0);

    // A few random nonzero pairs.
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(1, 60));
      rb = 8'($urandom_range(1, 60));
      expect_pair(ra, rb);
      load_pair(ra, rb);
      wait_result(1'b0, 0);
    end

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 Parameter MAX_ITER, default 255: the maximum number of subtractions allowed per operand pair before an error is flagged.
REQ-002 Parameter CNT_WID, default 9: the width of iter_cnt, which SHALL be able to hold MAX_ITER.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port i_rst, input, 1 bit: synchronous reset, active-high.
REQ-005 Port in_valid, input, 1 bit: an operand is present on the datapath data_input bus.
REQ-006 Port in_ready, output, 1 bit: the controller accepts an operand this cycle.
REQ-007 Port out_valid, output, 1 bit: a result (or error) is available; the result is read from the datapath out_A.
REQ-008 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 Port err, output, 1 bit: qualifies out_valid; 1 means timeout or illegal flags, and out_A is invalid.
REQ-010 Ports EQ, LT, GT, input, 1 bit each: datapath comparator flags for A==B, A<B, A>B.
REQ-011 Ports load_A, load_B, output, 1 bit each: datapath register load enables.
REQ-012 Port s_in1, output, 1 bit: subtractor left-operand mux select; 0 = out_A, 1 = out_B.
REQ-013 Port s_in2, output, 1 bit: subtractor right-operand mux select; 0 = out_A, 1 = out_B.
REQ-014 Port s_in3, output, 1 bit: register input mux select; 1 = data_input, 0 = Sub_out (left minus right).
REQ-015 Port busy, output, 1 bit: high in RUN.
REQ-016 Port iter_cnt, output, CNT_WID bits: the number of subtractions performed for the current pair.

Function
REQ-017 The controller SHALL have the states LD_A, LD_B, RUN, DONE and ERR, encoded in one state register.
REQ-018 LD_A: in_ready=1, s_in3=1, load_A=in_valid; on in_valid, go to LD_B.
REQ-019 LD_B: in_ready=1, s_in3=1, load_B=in_valid; on in_valid, go to RUN and clear iter_cnt to 0.
REQ-020 RUN evaluates EQ, LT and GT every cycle, and the first matching rule below SHALL win.
REQ-021 RUN rule (a): flags not exactly one-hot -> go to ERR, with no load.
REQ-022 RUN rule (b): EQ -> go to DONE, with no load.
REQ-023 RUN rule (c): iter_cnt==MAX_ITER -> go to ERR, with no load.
REQ-024 RUN rule (d): GT -> s_in1=0, s_in2=1, s_in3=0, load_A=1 (A<=A-B), iter_cnt+1, stay in RUN.
REQ-025 RUN rule (e): LT -> s_in1=1, s_in2=0, s_in3=0, load_B=1 (B<=B-A), iter_cnt+1, stay in RUN.
REQ-026 The datapath performs exactly one subtraction per RUN cycle, and the flags observed in RUN reflect the registers loaded on the previous edge.
REQ-027 DONE: out_valid=1, err=0, no loads; on out_ready, go to LD_A.
REQ-028 ERR: out_valid=1, err=1, no loads; on out_ready, go to LD_A.
REQ-029 out_valid SHALL be a Moore output, so the minimum DONE/ERR residency is 1 cycle even when out_ready is already high on entry.
REQ-030 in_ready=0 in RUN, DONE and ERR; in_valid is ignored in those states.
REQ-031 load_A and load_B SHALL never both be 1 in the same cycle.
REQ-032 All unlisted outputs are 0 in each state; the s_in* outputs are 0 when they are don't-care.
REQ-033 iter_cnt SHALL hold its value in DONE and ERR, and SHALL be cleared only on operand-B accept or reset.
REQ-034 A (0,0) operand pair gives EQ on the first RUN cycle: DONE with result 0 and err=0.
REQ-035 A single zero operand causes endless subtraction of 0, which SHALL end in ERR via rule (c).
REQ-036 The latency from the B accept to out_valid SHALL be iter_cnt+1 cycles.

Reset
REQ-037 On a rising edge with i_rst=1: state<=LD_A and iter_cnt<=0, from any state including mid-RUN.
REQ-038 While i_rst=1, all outputs SHALL be 0, with in_ready gated low.
REQ-039 In the first cycle after i_rst falls, in_ready=1.
REQ-040 No partial operand or result survives reset; the datapath registers are not cleared but are reloaded before the next use.

Verification
REQ-041 Scenario (12,8): 12 and 8 accepted on consecutive cycles -> RUN: GT (A=4), LT (B=4), EQ -> DONE; out_A=4, iter_cnt=2, err=0, latency 3.
REQ-042 Scenario (255,1): 254 GT subtractions, then EQ -> DONE, out_A=1, iter_cnt=254, err=0, with no ERR at the bound.
REQ-043 Scenario (5,0): GT every cycle -> after 255 subtractions, ERR with iter_cnt=255, err=1, out_valid=1.
REQ-044 Scenario (0,0) and forced EQ&GT: (0,0) -> DONE with out_A=0 and iter_cnt=0; forcing EQ=GT=1 in RUN -> ERR on the next edge.
REQ-045 Scenario backpressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1, no loads, in_valid pulses ignored; out_ready=1 -> LD_A on the next cycle.
REQ-046 Scenario reset mid-RUN of (200,3): i_rst=1 for 1 cycle -> state LD_A, iter_cnt=0, all outputs 0 during reset; a new pair (9,6) then gives 3.
